// File: rtl/cdb_broadcaster_pkg.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster_pkg
//   Shared definitions for the Common Data Bus broadcaster: ROB tag width,
//   the broadcast packet layout (maps 1:1 onto the ROB's CDB input packet)
//   and a small index helper.
// -----------------------------------------------------------------------------
package cdb_broadcaster_pkg;

   localparam int ROB_TAG_BITS = 6;
   localparam int VALUE_BITS   = 32;

   // One CDB broadcast: valid flag, ROB tag and result value.
   typedef struct packed {
      logic                    valid;
      logic [ROB_TAG_BITS-1:0] tag;
      logic [VALUE_BITS-1:0]   value;
   } cdb_packet_t;

   // Cyclic successor of idx in the range 0..n-1.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster_if
//   Bundles the functional-unit completion ports and the CDB broadcast outputs.
//   master : the FU / consumer side (drives fu_*, cdb_flush; sees ready + bus)
//   slave  : the broadcaster itself
//   Signals:
//     fu_valid/fu_tag/fu_value  per-FU completed result offer
//     fu_ready                  per-FU acceptance (no dependency on fu_valid)
//     cdb_flush                 squash all held and in-flight results
//     cdb_valid/tag/value       registered broadcast
//     cdb_stall_count           saturating count of contended cycles
// -----------------------------------------------------------------------------
interface cdb_broadcaster_if #(
   parameter int NUM_FU     = 4,
   parameter int STALL_BITS = 16
);
   import cdb_broadcaster_pkg::*;

   logic [NUM_FU-1:0]                   fu_valid;
   logic [NUM_FU-1:0][ROB_TAG_BITS-1:0] fu_tag;
   logic [NUM_FU-1:0][VALUE_BITS-1:0]   fu_value;
   logic [NUM_FU-1:0]                   fu_ready;
   logic                                cdb_flush;
   logic                                cdb_valid;
   logic [ROB_TAG_BITS-1:0]             cdb_tag;
   logic [VALUE_BITS-1:0]               cdb_value;
   logic [STALL_BITS-1:0]               cdb_stall_count;

   modport master (
      output fu_valid, fu_tag, fu_value, cdb_flush,
      input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_stall_count
   );

   modport slave (
      input  fu_valid, fu_tag, fu_value, cdb_flush,
      output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_stall_count
   );

endinterface

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Grants the first asserted request
//   found when scanning upward from index ptr, wrapping modulo N.
//   Ports:
//     req   in  N      request vector
//     ptr   in  PTR_W  starting (highest-priority) index
//     grant out N      one-hot grant, all zero when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   logic             found;
   logic [PTR_W:0]   sum;
   logic [PTR_W:0]   wrapped;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant   = '0;
      found   = 1'b0;
      sum     = '0;
      wrapped = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         // One extra bit holds ptr+k before the modulo-N fold.
         sum     = {1'b0, ptr} + (PTR_W+1)'(k);
         wrapped = (sum >= (PTR_W+1)'(N)) ? sum - (PTR_W+1)'(N) : sum;
         idx     = wrapped[PTR_W-1:0];
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster
//   Collects completed results from NUM_FU functional units into one-entry
//   holding registers and broadcasts one per cycle on a registered Common Data
//   Bus, using a round-robin arbiter across the held results. A flush drops
//   everything held or about to be broadcast.
//   Ports:
//     clock  in  system clock
//     reset  in  asynchronous active-high reset
//     bus    slave modport of cdb_broadcaster_if (FU offers, ready, CDB, stall count)
// -----------------------------------------------------------------------------
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int NUM_FU     = 4,
   parameter int STALL_BITS = 16
) (
   input  logic             clock,
   input  logic             reset,
   cdb_broadcaster_if.slave bus
);

   localparam int PTR_W = $clog2(NUM_FU);

   logic [NUM_FU-1:0]       hold_valid;
   logic [ROB_TAG_BITS-1:0] hold_tag   [NUM_FU];
   logic [VALUE_BITS-1:0]   hold_value [NUM_FU];
   logic [NUM_FU-1:0]       grant;
   logic [NUM_FU-1:0]       fu_ready;
   logic [NUM_FU-1:0]       accept;

   logic [PTR_W-1:0]        rr_ptr_reg;
   logic [PTR_W-1:0]        rr_ptr_next;
   logic [PTR_W-1:0]        grant_idx;
   cdb_packet_t             cdb_reg;
   cdb_packet_t             cdb_next;
   logic [STALL_BITS-1:0]   stall_reg;
   logic                    contention;

   // Arbitration looks only at held results, so fu_ready never depends on fu_valid.
   rr_arbiter #(.N(NUM_FU), .PTR_W(PTR_W)) u_arb (
      .req   (hold_valid),
      .ptr   (rr_ptr_reg),
      .grant (grant)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FU; gi++) begin : g_hold
         logic                    hold_valid_reg;
         logic [ROB_TAG_BITS-1:0] hold_tag_reg;
         logic [VALUE_BITS-1:0]   hold_value_reg;

         // Ready when empty or draining this cycle; during a flush the offer is
         // acknowledged so the FU drops it, but it is not captured.
         assign fu_ready[gi] = bus.cdb_flush | ~hold_valid_reg | grant[gi];
         assign accept[gi]   = bus.fu_valid[gi] & fu_ready[gi];

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               hold_valid_reg <= 1'b0;
               hold_tag_reg   <= '0;
               hold_value_reg <= '0;
            end else if (bus.cdb_flush) begin
               hold_valid_reg <= 1'b0;
            end else if (accept[gi]) begin
               // Covers the back-to-back case: refill while the old entry is granted.
               hold_valid_reg <= 1'b1;
               hold_tag_reg   <= bus.fu_tag[gi];
               hold_value_reg <= bus.fu_value[gi];
            end else if (grant[gi]) begin
               hold_valid_reg <= 1'b0;
            end
         end

         assign hold_valid[gi] = hold_valid_reg;
         assign hold_tag[gi]   = hold_tag_reg;
         assign hold_value[gi] = hold_value_reg;
      end
   endgenerate

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
      rr_ptr_next = PTR_W'(wrap_inc(int'(grant_idx), NUM_FU));

      // Tag/value keep their last value when nothing is granted.
      cdb_next       = cdb_reg;
      cdb_next.valid = 1'b0;
      if (|grant) begin
         cdb_next.valid = 1'b1;
         cdb_next.tag   = hold_tag[grant_idx];
         cdb_next.value = hold_value[grant_idx];
      end

      contention = ($countones(hold_valid) >= 2);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr_reg <= '0;
         cdb_reg    <= '0;
         stall_reg  <= '0;
      end else begin
         if (contention && !(&stall_reg)) begin
            stall_reg <= stall_reg + STALL_BITS'(1);
         end
         if (bus.cdb_flush) begin
            // Pointer is deliberately left alone so fairness survives a flush.
            cdb_reg.valid <= 1'b0;
         end else begin
            cdb_reg <= cdb_next;
            if (|grant) rr_ptr_reg <= rr_ptr_next;
         end
      end
   end

   assign bus.fu_ready        = fu_ready;
   assign bus.cdb_valid       = cdb_reg.valid;
   assign bus.cdb_tag         = cdb_reg.tag;
   assign bus.cdb_value       = cdb_reg.value;
   assign bus.cdb_stall_count = stall_reg;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// tb_cdb_broadcaster
//   Directed bench for cdb_broadcaster with a cycle model and an expected-result
//   queue. A narrow stall counter is used so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_cdb_broadcaster;
   import cdb_broadcaster_pkg::*;

   localparam int N    = 4;
   localparam int SB   = 4;
   localparam int SMAX = 15;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   cdb_broadcaster_if #(.NUM_FU(N), .STALL_BITS(SB)) bus ();

   cdb_broadcaster #(.NUM_FU(N), .STALL_BITS(SB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [ROB_TAG_BITS-1:0] tag;
      logic [31:0]             value;
   } exp_t;

   int   vectors     = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   bit                      m_hv  [N];
   logic [ROB_TAG_BITS-1:0] m_tag [N];
   logic [31:0]             m_val [N];
   int                      m_ptr;
   int                      m_stall;
   bit                      exp_valid;
   logic [N-1:0]            m_ready;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_hv[i]  = 1'b0;
         m_tag[i] = '0;
         m_val[i] = '0;
      end
      m_ptr   = 0;
      m_stall = 0;
      exp_q.delete();
   endtask

   task automatic clear_inputs();
      bus.fu_valid  = '0;
      bus.cdb_flush = 1'b0;
   endtask

   task automatic offer(input int fu, input int tag, input logic [31:0] v);
      bus.fu_valid[fu] = 1'b1;
      bus.fu_tag[fu]   = ROB_TAG_BITS'(tag);
      bus.fu_value[fu] = v;
   endtask

   // One clock: model predicts at the falling edge, DUT is compared 1ns after the rising edge.
   task automatic cycle();
      int   g;
      int   cnt;
      exp_t e;
      @(negedge clock);
      g = -1;
      for (int k = 0; k < N; k++) begin
         if (g < 0 && m_hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      for (int i = 0; i < N; i++) m_ready[i] = bus.cdb_flush || !m_hv[i] || (g == i);
      check("fu_ready", 64'(bus.fu_ready), 64'(m_ready));
      cnt = 0;
      for (int i = 0; i < N; i++) cnt += int'(m_hv[i]);
      if (cnt >= 2 && m_stall < SMAX) m_stall++;
      exp_valid = !bus.cdb_flush && (g >= 0);
      if (exp_valid) begin
         e.tag   = m_tag[g];
         e.value = m_val[g];
         exp_q.push_back(e);
      end
      if (bus.cdb_flush) begin
         for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      end else begin
         if (g >= 0) begin
            m_hv[g] = 1'b0;
            m_ptr   = (g + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            if (bus.fu_valid[i] && m_ready[i]) begin
               m_hv[i]  = 1'b1;
               m_tag[i] = bus.fu_tag[i];
               m_val[i] = bus.fu_value[i];
            end
         end
      end
      @(posedge clock);
      #1;
      check("cdb_valid", 64'(bus.cdb_valid), 64'(exp_valid));
      if (exp_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("cdb_tag", 64'(bus.cdb_tag), 64'(e.tag));
         check("cdb_value", 64'(bus.cdb_value), 64'(e.value));
      end
      check("stall_count", 64'(bus.cdb_stall_count), 64'(m_stall));
      $display("t=%0t valid=%0b tag=%0d value=%08h ready=%04b stall=%0d",
               $time, bus.cdb_valid, bus.cdb_tag, bus.cdb_value, bus.fu_ready, bus.cdb_stall_count);
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int exp3 [4] = '{1, 2, 3, 4};
      int t0;
      int t20;
      int ts;

      bus.fu_tag   = '0;
      bus.fu_value = '0;
      clear_inputs();
      model_reset();

      // 1: reset state
      do_reset();
      check("rst_valid", 64'(bus.cdb_valid), 64'd0);
      check("rst_tag", 64'(bus.cdb_tag), 64'd0);
      check("rst_value", 64'(bus.cdb_value), 64'd0);
      check("rst_ready", 64'(bus.fu_ready), 64'b1111);
      check("rst_stall", 64'(bus.cdb_stall_count), 64'd0);

      // 2: single result, visible one edge after acceptance, for one cycle only
      offer(1, 5, 32'h12345678);
      cycle();
      check("single_not_early", 64'(bus.cdb_valid), 64'd0);
      clear_inputs();
      cycle();
      check("single_tag", 64'(bus.cdb_tag), 64'd5);
      check("single_value", 64'(bus.cdb_value), 64'h12345678);
      cycle();
      check("single_once", 64'(bus.cdb_valid), 64'd0);

      // 3: contention from rr_ptr=0
      do_reset();
      for (int i = 0; i < N; i++) offer(i, i + 1, 32'hA000_0000 + 32'(i));
      cycle();
      clear_inputs();
      check("cont_ready", 64'(bus.fu_ready), 64'b0001);
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("cont_tag", 64'(bus.cdb_tag), 64'(exp3[i]));
      end
      check("cont_stall", 64'(bus.cdb_stall_count), 64'd3);
      cycle();

      // 4: fairness, FU0 streams while FU2 offers once
      t0 = 8;
      offer(0, t0, $urandom);
      offer(2, 20, 32'h0000_0020);
      cycle();
      t0++;
      clear_inputs();
      t20 = -1;
      for (int k = 1; k <= 8; k++) begin
         offer(0, t0, $urandom);
         cycle();
         if (m_ready[0]) t0++;
         if (bus.cdb_valid && bus.cdb_tag == 6'd20) t20 = k;
      end
      check("fair_latency", 64'(t20), 64'd2);
      clear_inputs();
      repeat (3) cycle();

      // 5: flush drops held results and the offer made during the flush
      offer(1, 6, 32'h66);
      offer(3, 7, 32'h77);
      cycle();
      clear_inputs();
      bus.cdb_flush = 1'b1;
      offer(0, 30, 32'h30);
      #1;
      check("flush_ready_during", 64'(bus.fu_ready), 64'b1111);
      cycle();
      check("flush_valid", 64'(bus.cdb_valid), 64'd0);
      clear_inputs();
      #1;
      check("flush_ready_after", 64'(bus.fu_ready), 64'b1111);
      repeat (2) cycle();

      // 6: back-to-back from one FU
      offer(2, 10, 32'h1010);
      cycle();
      offer(2, 11, 32'h1111);
      #1;
      check("b2b_ready0", 64'(bus.fu_ready[2]), 64'd1);
      cycle();
      check("b2b_tag10", 64'(bus.cdb_tag), 64'd10);
      clear_inputs();
      #1;
      check("b2b_ready1", 64'(bus.fu_ready[2]), 64'd1);
      cycle();
      check("b2b_tag11", 64'(bus.cdb_tag), 64'd11);
      cycle();

      // 7: stall counter saturates under sustained contention
      ts = 32;
      for (int k = 0; k < 20; k++) begin
         offer(0, ts, $urandom);
         offer(1, ts + 1, $urandom);
         cycle();
         ts = (ts >= 60) ? 32 : ts + 2;
      end
      check("stall_sat", 64'(bus.cdb_stall_count), 64'(SMAX));
      clear_inputs();
      repeat (3) cycle();

      // 8: asynchronous reset mid-operation loses pending results
      offer(0, 40, 32'h40);
      offer(1, 41, 32'h41);
      offer(2, 42, 32'h42);
      cycle();
      clear_inputs();
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", 64'(bus.cdb_valid), 64'd0);
      check("arst_stall", 64'(bus.cdb_stall_count), 64'd0);
      check("arst_ready", 64'(bus.fu_ready), 64'b1111);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      repeat (2) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
